sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Arbitrates two requesters (m0 = instruction fetch, m1 = data) onto a
// single-port synchronous SRAM.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   mX_req/addr/web/wdata        requester X access; web is active-low byte
//                                write enables, 4'b1111 = read
//   mX_gnt                       request accepted this cycle (combinational)
//   mX_rvalid/mX_rdata           read response, one cycle after the grant
//   sram_cs/oe/web/a/di          SRAM control, address and write data
//   sram_do                      SRAM read data, valid one cycle after sampling
//
// Grants are combinational from req and a one-bit last-granted pointer.
// When both requesters contend, the one that did not win last time wins.
module sram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_web,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_web,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic [3:0]        sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);

  logic last_gnt_q, last_gnt_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_id_q, rsp_id_d;
  logic gnt_id;
  logic rd_grant;

  // Grant: a lone requester wins outright; on contention the requester
  // that was not granted last wins. Reset masks all grants.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        m0_gnt = last_gnt_q;
        m1_gnt = ~last_gnt_q;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign gnt_id  = m1_gnt;
  assign sram_cs = m0_gnt | m1_gnt;
  assign sram_oe = 1'b1;

  // SRAM mux; idle bus is a read-disabled all-zero access.
  always_comb begin
    sram_web = 4'b1111;
    sram_a   = '0;
    sram_di  = '0;
    if (m0_gnt) begin
      sram_web = m0_web;
      sram_a   = m0_addr;
      sram_di  = m0_wdata;
    end else if (m1_gnt) begin
      sram_web = m1_web;
      sram_a   = m1_addr;
      sram_di  = m1_wdata;
    end
  end

  assign rd_grant = sram_cs && (sram_web == 4'b1111);

  always_comb begin
    last_gnt_d  = sram_cs ? gnt_id : last_gnt_q;
    rsp_valid_d = rd_grant;
    rsp_id_d    = rd_grant ? gnt_id : 1'b0;
  end

  // Reset clears any pending response at once, so it can never surface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q  <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // sram_do is valid in the cycle after the read edge, which is exactly
  // the cycle the registered response flags are up.
  assign m0_rvalid = rsp_valid_q & ~rsp_id_q;
  assign m1_rvalid = rsp_valid_q &  rsp_id_q;
  assign m0_rdata  = m0_rvalid ? sram_do : '0;
  assign m1_rdata  = m1_rvalid ? sram_do : '0;

endmodule
